// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit (master) and the RAM / execute side (slave).
// Build option IFU_ALIGN_CHECK_EN adds the align_fault signal.
interface instr_fetch_unit_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic                    mem_cs;
   logic                    mem_oe;
   logic                    mem_we;
   logic [DATA_WIDTH-1:0]   mem_rdata;
   logic [2*DATA_WIDTH-1:0] ir_out;
   logic [ADDR_WIDTH-1:0]   ir_pc;
   logic                    ir_valid;
   logic                    ir_ready;
   logic                    redirect_valid;
   logic [ADDR_WIDTH-1:0]   redirect_pc;
   logic                    halted;
`ifdef IFU_ALIGN_CHECK_EN
   logic                    align_fault;
`endif

   modport master (
      output mem_addr, mem_cs, mem_oe, mem_we,
      input  mem_rdata,
      output ir_out, ir_pc, ir_valid,
      input  ir_ready, redirect_valid, redirect_pc,
      output halted
`ifdef IFU_ALIGN_CHECK_EN
      , output align_fault
`endif
   );

   modport slave (
      input  mem_addr, mem_cs, mem_oe, mem_we,
      output mem_rdata,
      input  ir_out, ir_pc, ir_valid,
      output ir_ready, redirect_valid, redirect_pc,
      input  halted
`ifdef IFU_ALIGN_CHECK_EN
      , input align_fault
`endif
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch stage for the 8-bit accumulator CPU.
// Build option IFU_ALIGN_CHECK_EN: odd redirect targets raise align_fault and halt.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   instr_fetch_unit_if.master    bus,
   output logic [2:0]            dbg_state_o
);
   // Handshake: an instruction transfers on a rising edge where ir_valid && ir_ready;
   // ir_out/ir_pc stay stable while ir_valid is high and not yet accepted.
   typedef enum logic [2:0] {
      S_FETCH_HI = 3'd0,
      S_FETCH_LO = 3'd1,
      S_CAPTURE  = 3'd2,
      S_VALID    = 3'd3,
      S_HALTED   = 3'd4
   } state_e;

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   pc_q;
   logic [DATA_WIDTH-1:0]   hi_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic                    mem_cs_q;
   logic                    mem_oe_q;
   logic [2*DATA_WIDTH-1:0] ir_out_q;
   logic [ADDR_WIDTH-1:0]   ir_pc_q;
   logic                    ir_valid_q;
   logic                    halted_q;
`ifdef IFU_ALIGN_CHECK_EN
   logic                    align_fault_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH_HI;
         pc_q       <= RESET_PC;
         hi_q       <= '0;
         mem_addr_q <= '0;
         mem_cs_q   <= 1'b0;
         mem_oe_q   <= 1'b0;
         ir_out_q   <= '0;
         ir_pc_q    <= '0;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
         align_fault_q <= 1'b0;
`endif
      end else if (bus.redirect_valid) begin
         // Redirect beats any state and a same-cycle handshake; partial fetches are dropped.
         mem_cs_q   <= 1'b0;
         mem_oe_q   <= 1'b0;
         ir_valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
         if (bus.redirect_pc[0]) begin
            align_fault_q <= 1'b1;
            halted_q      <= 1'b1;
            state_q       <= S_HALTED;
         end else begin
            halted_q <= 1'b0;
            pc_q     <= bus.redirect_pc;
            state_q  <= S_FETCH_HI;
         end
`else
         halted_q <= 1'b0;
         pc_q     <= bus.redirect_pc;
         state_q  <= S_FETCH_HI;
`endif
      end else begin
         case (state_q)
            S_FETCH_HI: begin
               mem_addr_q <= pc_q;
               mem_cs_q   <= 1'b1;
               mem_oe_q   <= 1'b1;
               state_q    <= S_FETCH_LO;
            end
            S_FETCH_LO: begin
               mem_addr_q <= pc_q + ADDR_WIDTH'(1);
               hi_q       <= bus.mem_rdata;
               state_q    <= S_CAPTURE;
            end
            S_CAPTURE: begin
               mem_cs_q   <= 1'b0;
               mem_oe_q   <= 1'b0;
               ir_out_q   <= {hi_q, bus.mem_rdata};
               ir_pc_q    <= pc_q;
               pc_q       <= pc_q + ADDR_WIDTH'(2);
               ir_valid_q <= 1'b1;
               state_q    <= S_VALID;
            end
            S_VALID: begin
               if (bus.ir_ready) begin
                  ir_valid_q <= 1'b0;
                  if (ir_out_q[2*DATA_WIDTH-1 -: 4] == 4'h7) begin
                     halted_q <= 1'b1;
                     state_q  <= S_HALTED;
                  end else begin
                     state_q <= S_FETCH_HI;
                  end
               end
            end
            S_HALTED: begin
               state_q <= S_HALTED;
            end
            default: begin
               state_q <= S_FETCH_HI;
            end
         endcase
      end
   end

   assign bus.mem_addr = mem_addr_q;
   assign bus.mem_cs   = mem_cs_q;
   assign bus.mem_oe   = mem_oe_q;
   assign bus.mem_we   = 1'b0;
   assign bus.ir_out   = ir_out_q;
   assign bus.ir_pc    = ir_pc_q;
   assign bus.ir_valid = ir_valid_q;
   assign bus.halted   = halted_q;
`ifdef IFU_ALIGN_CHECK_EN
   assign bus.align_fault = align_fault_q;
`endif
   assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random traffic against a fetch-timeline model.
// Build option IFU_ALIGN_CHECK_EN enables the alignment-fault scenario.
module tb_instr_fetch_unit;
   logic       clk;
   logic       rst_n;
   logic [2:0] dbg_state;
   logic [7:0] mem [256];
   int         tests_run;
   int         tests_failed;

   instr_fetch_unit_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

   instr_fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .RESET_PC(8'h00)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM: read data for the presented address is available before the next rising edge
   assign bus.mem_rdata = (bus.mem_cs && bus.mem_oe) ? mem[bus.mem_addr] : 8'h00;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_t counts cycles since the current fetch began; the word is offered from m_t==3 on.
   logic [7:0] m_pc;
   int         m_t;
   bit         m_halted;
   bit         m_align;
   bit         checking;

   initial begin
      m_pc = 8'h00; m_t = 0; m_halted = 0; m_align = 0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc = 8'h00; m_t = 0; m_halted = 0; m_align = 0;
      end else if (bus.redirect_valid) begin
`ifdef IFU_ALIGN_CHECK_EN
         if (bus.redirect_pc[0]) begin
            m_halted = 1; m_align = 1;
         end else begin
            m_pc = bus.redirect_pc; m_t = 0; m_halted = 0;
         end
`else
         m_pc = bus.redirect_pc; m_t = 0; m_halted = 0;
`endif
      end else if (!m_halted) begin
         if (m_t < 3) m_t++;
         else if (bus.ir_ready) begin
            if (mem[m_pc][7:4] == 4'h7) m_halted = 1;
            else begin
               m_pc = m_pc + 8'd2;
               m_t  = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (checking) begin
         logic       exp_valid, exp_cs;
         logic [7:0] pc1;
         pc1       = m_pc + 8'd1;
         exp_valid = rst_n && !m_halted && (m_t == 3);
         exp_cs    = rst_n && !m_halted && (m_t == 1 || m_t == 2);
         check("ir_valid", bus.ir_valid, exp_valid);
         check("mem_cs", bus.mem_cs, exp_cs);
         check("mem_oe", bus.mem_oe, exp_cs);
         check("mem_we", bus.mem_we, 0);
         check("halted", bus.halted, rst_n && m_halted);
`ifdef IFU_ALIGN_CHECK_EN
         check("align_fault", bus.align_fault, rst_n && m_align);
`endif
         if (!rst_n) begin
            check("rst_ir_out", bus.ir_out, 0);
            check("rst_ir_pc", bus.ir_pc, 0);
            check("rst_mem_addr", bus.mem_addr, 0);
         end
         if (exp_cs) check("mem_addr", bus.mem_addr, (m_t == 1) ? m_pc : pc1);
         if (exp_valid) begin
            check("ir_out", bus.ir_out, {mem[m_pc], mem[pc1]});
            check("ir_pc", bus.ir_pc, m_pc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [7:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
      tick(1);
      bus.redirect_valid = 1'b0;
   endtask

   task automatic wait_valid(input int max_cycles, input string name);
      int n = 0;
      while (bus.ir_valid !== 1'b1 && n < max_cycles) begin
         tick(1);
         n++;
      end
      check(name, bus.ir_valid, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tests_run = 0; tests_failed = 0; checking = 0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      mem[8'h00] = 8'h11; mem[8'h01] = 8'h0C; mem[8'h02] = 8'h21; mem[8'h03] = 8'h0E;
      mem[8'h04] = 8'h35;
      mem[8'hFE] = 8'hA0; mem[8'hFF] = 8'h00;
      mem[8'h14] = 8'h70; mem[8'h15] = 8'h00;
      rst_n = 1'b0; bus.ir_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 8'h00;
      #1 checking = 1;
      tick(3);
      check("reset_ir_valid", bus.ir_valid, 0);
      check("reset_mem_cs", bus.mem_cs, 0);
      check("reset_halted", bus.halted, 0);

      // first word: exactly 3 cycles after release, held under backpressure
      rst_n = 1'b1;
      tick(3);
      check("first_latency", bus.ir_valid, 1);
      check("first_ir_out", bus.ir_out, 16'h110C);
      check("first_ir_pc", bus.ir_pc, 8'h00);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("bp_ir_out", bus.ir_out, 16'h110C);
         check("bp_mem_cs", bus.mem_cs, 0);
      end
      bus.ir_ready = 1'b1;
      tick(1);
      check("accept_drops_valid", bus.ir_valid, 0);
      tick(3);
      check("second_ir_out", bus.ir_out, 16'h210E);
      check("second_ir_pc", bus.ir_pc, 8'h02);

      // redirect during FETCH_LO of 'h00 aborts that fetch
      redirect(8'h00);
      tick(1);
      check("fetch_lo_cs", bus.mem_cs, 1);
      check("fetch_lo_addr", bus.mem_addr, 8'h00);
      redirect(8'h02);
      wait_valid(8, "redir_timeout");
      check("redir_ir_out", bus.ir_out, 16'h210E);
      check("redir_ir_pc", bus.ir_pc, 8'h02);

      // wrap-around
      redirect(8'hFE);
      wait_valid(8, "wrap_timeout");
      check("wrap_ir_out", bus.ir_out, 16'hA000);
      check("wrap_ir_pc", bus.ir_pc, 8'hFE);
      tick(2);
      check("wrap_next_addr", bus.mem_addr, 8'h00);
      check("wrap_next_cs", bus.mem_cs, 1);

      // halt and recovery
      redirect(8'h14);
      wait_valid(8, "halt_timeout");
      check("halt_ir_out", bus.ir_out, 16'h7000);
      tick(1);
      check("halted_set", bus.halted, 1);
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("halted_cs", bus.mem_cs, 0);
      end
      redirect(8'h00);
      check("halted_cleared", bus.halted, 0);
      wait_valid(8, "unhalt_timeout");
      check("unhalt_ir_out", bus.ir_out, 16'h110C);

      // reset during CAPTURE
      redirect(8'h02);
      tick(2);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", bus.ir_valid, 0);
      check("async_rst_cs", bus.mem_cs, 0);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check("restart_valid", bus.ir_valid, 1);
      check("restart_ir_out", bus.ir_out, 16'h110C);
      check("restart_ir_pc", bus.ir_pc, 8'h00);

`ifdef IFU_ALIGN_CHECK_EN
      redirect(8'h03);
      check("align_fault_set", bus.align_fault, 1);
      check("align_halted", bus.halted, 1);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         check("align_cs", bus.mem_cs, 0);
      end
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("align_cleared", bus.align_fault, 0);
`else
      redirect(8'h03);
      wait_valid(8, "odd_timeout");
      check("odd_ir_out", bus.ir_out, 16'h0E35);
      check("odd_ir_pc", bus.ir_pc, 8'h03);
`endif

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         bus.ir_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 11) == 0) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = 8'($urandom_range(0, 255));
`ifdef IFU_ALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) bus.redirect_pc[0] = 1'b0;
`endif
         end else begin
            bus.redirect_valid = 1'b0;
         end
         rst_n = ($urandom_range(0, 199) != 0);
         tick(1);
      end
      rst_n = 1'b1;
      bus.redirect_valid = 1'b0;
      tick(2);
      checking = 0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      tests_failed++;
      $display("FAIL watchdog: bench did not complete, dut state %0d", dbg_state);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
